// File: rtl/mem_writeback.sv
// mem_writeback: retires one execute-stage result bundle.
// Latches the bundle on start and runs the data-memory handshake for loads and
// stores. It then performs the register-file write and the PC update, and
// pulses done. All outputs come straight from flops.
module mem_writeback #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] result,
    input  logic        mem_write_enabled,
    input  logic        mem_read_enabled,
    input  logic [31:0] mem_write_dest,
    input  logic        reg_write_enabled,
    input  logic [4:0]  reg_write_dest,
    input  logic        is_jump_enabled,
    input  logic [31:0] jump_dest,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] next_pc,
    output logic        done,
    output logic        err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Latched copy of the execute bundle
    logic [31:0] r_pc;
    logic [31:0] r_result;
    logic        r_is_load;     // load without a store flag: writes memory data
    logic        r_rwe;
    logic [4:0]  r_rd;
    logic        r_jmp;
    logic [31:0] r_jdest;
    logic        r_issued;      // a memory request was issued for this instruction
    logic [7:0]  r_cnt;

    // Registered outputs
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic [31:0] r_next_pc;
    logic        r_done;
    logic        r_err;

    // Decode of the incoming bundle
    logic        w_accept;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_start_err;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_mem_end;

    // Output-logic results
    logic        w_fire;
    logic        w_req_next;
    logic        w_rf_we_next;
    logic [31:0] w_ldata;
    logic [31:0] w_rf_wdata_next;
    logic [31:0] w_next_pc_next;
    logic        w_err_set;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_is_mem     = mem_write_enabled || mem_read_enabled;
    assign w_misaligned = w_is_mem && (mem_write_dest[1:0] != 2'b00);
    assign w_issue      = w_is_mem && !w_misaligned;
    assign w_start_err  = w_misaligned || (mem_write_enabled && mem_read_enabled);
    assign w_cnt_inc    = r_cnt + 8'd1;
    // An ack in the final allowed cycle still wins over the timeout
    assign w_timeout    = (r_state == S_MEM) && !dmem_ack && (w_cnt_inc == TIMEOUT_C);
    assign w_mem_end    = (r_state == S_MEM) && (dmem_ack || w_timeout);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_issue ? S_MEM : S_WB;
            S_MEM:   if (w_mem_end) w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic.
    // A memory instruction retires at the ack/timeout edge, so done lands one
    // cycle after the ack. The WB cycle that follows is then the done cycle
    // itself. A non-memory instruction retires at the end of its WB cycle.
    always_comb begin
        w_fire          = ((r_state == S_WB) && !r_issued) || w_mem_end;
        w_req_next      = w_accept ? w_issue : ((r_state == S_MEM) && !w_mem_end && r_dmem_req);
        w_ldata         = ((r_state == S_MEM) && dmem_ack) ? dmem_rdata : 32'h0;
        w_rf_we_next    = w_fire && r_rwe && (r_rd != 5'd0);
        w_rf_wdata_next = r_is_load ? w_ldata : r_result;
        w_next_pc_next  = r_jmp ? r_jdest : (r_pc + 32'd4);
        w_err_set       = (w_accept && w_start_err) || w_timeout;
    end

    // Bundle capture and MEM wait counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc      <= 32'h0;
            r_result  <= 32'h0;
            r_is_load <= 1'b0;
            r_rwe     <= 1'b0;
            r_rd      <= 5'd0;
            r_jmp     <= 1'b0;
            r_jdest   <= 32'h0;
            r_issued  <= 1'b0;
            r_cnt     <= 8'd0;
        end else if (w_accept) begin
            r_pc      <= pc;
            r_result  <= result;
            r_is_load <= mem_read_enabled && !mem_write_enabled;
            r_rwe     <= reg_write_enabled;
            r_rd      <= reg_write_dest;
            r_jmp     <= is_jump_enabled;
            r_jdest   <= jump_dest;
            r_issued  <= w_issue;
            r_cnt     <= 8'd0;
        end else if ((r_state == S_MEM) && !dmem_ack) begin
            r_cnt     <= w_cnt_inc;
        end
    end

    // Output registers; memory controls only change when a request is launched
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 32'h0;
            r_dmem_wdata <= 32'h0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= 5'd0;
            r_rf_wdata   <= 32'h0;
            r_next_pc    <= 32'h0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_dmem_req <= w_req_next;
            r_rf_we    <= w_rf_we_next;
            r_done     <= w_fire;
            if (w_err_set) r_err <= 1'b1;
            if (w_accept && w_issue) begin
                r_dmem_we    <= mem_write_enabled;
                r_dmem_addr  <= {mem_write_dest[31:2], 2'b00};
                r_dmem_wdata <= result;
            end
            if (w_fire) begin
                r_rf_waddr <= r_rd;
                r_rf_wdata <= w_rf_wdata_next;
                r_next_pc  <= w_next_pc_next;
            end
        end
    end

    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign next_pc    = r_next_pc;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: a vector table of retiring instructions
// plus hand-written sequences for faults, stray acks and mid-MEM reset.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc = '0, result = '0, mem_write_dest = '0, jump_dest = '0;
    logic        mem_write_enabled = 1'b0, mem_read_enabled = 1'b0;
    logic        reg_write_enabled = 1'b0, is_jump_enabled = 1'b0;
    logic [4:0]  reg_write_dest = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req, dmem_we, rf_we, done, err;
    logic [31:0] dmem_addr, dmem_wdata, rf_wdata, next_pc;
    logic [4:0]  rf_waddr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_writeback #(.TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .pc(pc), .result(result),
        .mem_write_enabled(mem_write_enabled), .mem_read_enabled(mem_read_enabled),
        .mem_write_dest(mem_write_dest), .reg_write_enabled(reg_write_enabled),
        .reg_write_dest(reg_write_dest), .is_jump_enabled(is_jump_enabled),
        .jump_dest(jump_dest), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .next_pc(next_pc), .done(done), .err(err)
    );

    typedef struct {
        string       name;
        logic [31:0] pc, result, dest, jdest, rdata;
        logic        st, ld, rwe, jmp;
        logic [4:0]  rd;
        int          ack_after;   // ack in the Nth request cycle; 0 = never ack
        int          exp_req;     // cycles dmem_req is expected high
        int          exp_done;    // cycle (counting from start edge) done is high
        logic        exp_rfwe;
        logic [31:0] exp_wdata, exp_npc;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(string name, logic [31:0] pc_i, logic [31:0] res_i,
                                logic st_i, logic ld_i, logic [31:0] dest_i,
                                logic rwe_i, logic [4:0] rd_i, logic jmp_i,
                                logic [31:0] jd_i, int ack_i, logic [31:0] rdata_i,
                                int ereq, int edone, logic erfwe,
                                logic [31:0] ewd, logic [31:0] enpc, logic eerr);
        vec_t v;
        v.name = name; v.pc = pc_i; v.result = res_i; v.st = st_i; v.ld = ld_i;
        v.dest = dest_i; v.rwe = rwe_i; v.rd = rd_i; v.jmp = jmp_i; v.jdest = jd_i;
        v.ack_after = ack_i; v.rdata = rdata_i; v.exp_req = ereq; v.exp_done = edone;
        v.exp_rfwe = erfwe; v.exp_wdata = ewd; v.exp_npc = enpc; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // Issue one instruction, play the memory side, and check the retire
    task automatic run_vec(input vec_t v);
        int cyc = 1;
        int reqs = 0;
        int done_at = -1;
        @(posedge clk); #1;
        pc = v.pc; result = v.result; mem_write_enabled = v.st; mem_read_enabled = v.ld;
        mem_write_dest = v.dest; reg_write_enabled = v.rwe; reg_write_dest = v.rd;
        is_jump_enabled = v.jmp; jump_dest = v.jdest; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // scramble inputs so the bench notices if the DUT does not latch them
        pc = ~v.pc; result = ~v.result; mem_write_dest = ~v.dest; jump_dest = ~v.jdest;
        reg_write_dest = ~v.rd;
        while (cyc <= 20) begin
            if (dmem_req) begin
                reqs++;
                chk({v.name, " dmem_we"}, {31'b0, dmem_we}, {31'b0, v.st});
                chk({v.name, " dmem_addr"}, dmem_addr, v.dest);
                chk({v.name, " dmem_wdata"}, dmem_wdata, v.result);
                if (reqs == v.ack_after) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = v.rdata;
                end
            end
            if (done) begin
                done_at = cyc;
                break;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            dmem_rdata = 32'hBAD0BAD0;
            cyc++;
        end
        dmem_ack = 1'b0;
        if (done_at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s done_wait: no done within 20 cycles", v.name);
        end else begin
            chk({v.name, " done_latency"}, done_at, v.exp_done);
            chk({v.name, " req_cycles"}, reqs, v.exp_req);
            chk({v.name, " rf_we"}, {31'b0, rf_we}, {31'b0, v.exp_rfwe});
            chk({v.name, " rf_waddr"}, {27'b0, rf_waddr}, {27'b0, v.rd});
            chk({v.name, " rf_wdata"}, rf_wdata, v.exp_wdata);
            chk({v.name, " next_pc"}, next_pc, v.exp_npc);
            chk({v.name, " err"}, {31'b0, err}, {31'b0, v.exp_err});
            @(posedge clk); #1;
            chk({v.name, " done_pulse"}, {30'b0, done, rf_we}, 32'h0);
        end
        $display("txn %-10s pc=%08h reqs=%0d done@%0d rf_we=%0b rd=%0d wdata=%08h npc=%08h err=%0b",
                 v.name, v.pc, reqs, done_at, rf_we, rf_waddr, rf_wdata, next_pc, err);
    endtask

    vec_t vecs[8];

    initial begin
        //            name       pc            result        st ld dest          rwe rd  jmp jdest       ack rdata         req done rfwe wdata         npc           err
        vecs[0] = mk("alu",     32'h1000,     32'h2A,       0, 0, 32'h0,        1, 5,  0, 32'h0,     0, 32'h0,         0, 2,   1, 32'h2A,       32'h1004,     0);
        vecs[1] = mk("store",   32'h2000,     32'hDEADBEEF, 1, 0, 32'h100,      0, 0,  0, 32'h0,     3, 32'h0,         3, 4,   0, 32'hDEADBEEF, 32'h2004,     0);
        vecs[2] = mk("load",    32'h2004,     32'h104,      0, 1, 32'h104,      1, 7,  0, 32'h0,     1, 32'h1234,      1, 2,   1, 32'h1234,     32'h2008,     0);
        vecs[3] = mk("jal",     32'h40,       32'h44,       0, 0, 32'h0,        1, 1,  1, 32'h80,    0, 32'h0,         0, 2,   1, 32'h44,       32'h80,       0);
        vecs[4] = mk("beq_nt",  32'h50,       32'h1,        0, 0, 32'h0,        0, 0,  0, 32'h90,    0, 32'h0,         0, 2,   0, 32'h1,        32'h54,       0);
        vecs[5] = mk("rd0",     32'h60,       32'h99,       0, 0, 32'h0,        1, 0,  0, 32'h0,     0, 32'h0,         0, 2,   0, 32'h99,       32'h64,       0);
        vecs[6] = mk("pc_wrap", 32'hFFFFFFFC, 32'h7,        0, 0, 32'h0,        1, 3,  0, 32'h0,     0, 32'h0,         0, 2,   1, 32'h7,        32'h0,        0);
        vecs[7] = mk("load2",   32'h70,       32'h0,        0, 1, 32'hFFC,      1, 31, 0, 32'h0,     2, 32'hCAFEF00D,  2, 3,   1, 32'hCAFEF00D, 32'h74,       0);

        // Reset state
        #2;
        chk("reset_outputs", {26'b0, dmem_req, dmem_we, rf_we, done, err, 1'b0}, 32'h0);
        chk("reset_next_pc", next_pc, 32'h0);
        chk("reset_dmem_addr", dmem_addr, 32'h0);
        do_reset();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // A stray ack while idle must do nothing
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("stray_ack", {29'b0, done, rf_we, err}, 32'h0);

        // Misaligned load: no request, writes 0, sets err
        run_vec(mk("misalign", 32'h80, 32'h55, 0, 1, 32'h102, 1, 3, 0, 32'h0, 1, 32'h77, 0, 2, 1, 32'h0, 32'h84, 1));

        // Load that never gets an ack: 4 request cycles, then abort with err
        do_reset();
        chk("err_cleared", {31'b0, err}, 32'h0);
        run_vec(mk("timeout", 32'h90, 32'h66, 0, 1, 32'h200, 1, 9, 0, 32'h0, 0, 32'h0, 4, 5, 1, 32'h0, 32'h94, 1));

        // Load and store both set: performed as a store, err raised
        do_reset();
        run_vec(mk("ld_st", 32'hA0, 32'h55, 1, 1, 32'h300, 0, 0, 0, 32'h0, 1, 32'h11, 1, 2, 0, 32'h55, 32'hA4, 1));

        // Async reset in the middle of a store request
        do_reset();
        @(posedge clk); #1;
        mem_write_enabled = 1'b1; mem_read_enabled = 1'b0; mem_write_dest = 32'h400;
        result = 32'h1; reg_write_enabled = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_mem_req_up", {31'b0, dmem_req}, 32'h1);
        // start again while in MEM must be ignored
        start = 1'b1; mem_write_enabled = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ignored_in_mem", {29'b0, dmem_req, dmem_we, done}, 32'h6);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset_req", {30'b0, dmem_req, done}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
